output_mem_readout: RTL

//  Downstream stage of the per-UUT processing testbench chain. On each done pulse from an output

---
 rtl/output_mem_readout.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/output_mem_readout.sv
// output_mem_readout: reads back one BX worth of output-memory entries after a
// done pulse and emits them as a framed stream (valid/first/last/BX) together
// with a per-BX word count, XOR checksum and overflow flag.
module output_mem_readout #(
   parameter int unsigned WIDTH      = 36,
   parameter int unsigned ADD_SIZE   = 6,
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned TMUX       = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en_proc,
   input  logic [2:0]          BX,
   input  logic [1:0]          start,
   output logic [1:0]          done,
   input  logic [5:0]          number_in,
   output logic [ADD_SIZE:0]   read_add,
   input  logic [WIDTH-1:0]    data_in,
   output logic [WIDTH-1:0]    data_out,
   output logic                valid_out,
   output logic                first_out,
   output logic                last_out,
   output logic [2:0]          bx_out,
   output logic [5:0]          word_count,
   output logic [WIDTH-1:0]    checksum,
   output logic                overflow,
   output logic                err_busy
);

   localparam int unsigned CNT_W    = 6;
   localparam int unsigned PW       = RD_LATENCY + 1;
   localparam int unsigned MAX_READ = TMUX - RD_LATENCY - 2;
   // Pipe stages strictly below RD_LATENCY-1; once these are empty the last
   // word is at most one cycle from its tap, so DONE lines up with it.
   localparam logic [PW-1:0] DRAIN_MASK = PW'((1 << (RD_LATENCY - 1)) - 1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_n;
   logic [CNT_W-1:0]  r_index;
   logic              r_page;
   logic [PW-1:0]     r_vpipe;
   logic [PW-1:0]     r_fpipe;
   logic [PW-1:0]     r_lpipe;
   logic              r_done0;
   logic              r_done1;

   logic              w_ovf;
   logic [CNT_W-1:0]  w_n;
   logic [CNT_W-1:0]  w_last_idx;
   logic              w_drain_ok;
   logic              w_accept;
   logic              w_vtap;

   assign w_ovf      = 32'(number_in) > MAX_READ;
   assign w_n        = w_ovf ? CNT_W'(MAX_READ) : number_in;
   assign w_last_idx = r_n - CNT_W'(1);
   assign w_drain_ok = (r_vpipe & DRAIN_MASK) == '0;
   assign w_accept   = (r_state == S_IDLE) && start[0] && !start[1] && en_proc;
   assign w_vtap     = r_vpipe[RD_LATENCY];

   assign done = {r_done1, r_done0};

   // Sync-clear echo: done[1] follows start[1] by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_done1 <= 1'b0;
      end else begin
         r_done1 <= start[1];
      end
   end

   // Readout FSM: address generation, valid/first/last tracking, BX summary latch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_n      <= '0;
         r_index  <= '0;
         r_page   <= 1'b0;
         r_vpipe  <= '0;
         r_fpipe  <= '0;
         r_lpipe  <= '0;
         r_done0  <= 1'b0;
         read_add <= '0;
         bx_out   <= '0;
         overflow <= 1'b0;
         err_busy <= 1'b0;
      end else if (start[1]) begin
         r_state  <= S_IDLE;
         r_n      <= '0;
         r_index  <= '0;
         r_page   <= 1'b0;
         r_vpipe  <= '0;
         r_fpipe  <= '0;
         r_lpipe  <= '0;
         r_done0  <= 1'b0;
         read_add <= '0;
         bx_out   <= '0;
         overflow <= 1'b0;
         err_busy <= 1'b0;
      end else begin
         r_done0 <= 1'b0;
         r_vpipe <= {r_vpipe[RD_LATENCY-1:0], 1'b0};
         r_fpipe <= {r_fpipe[RD_LATENCY-1:0], 1'b0};
         r_lpipe <= {r_lpipe[RD_LATENCY-1:0], 1'b0};
         if (start[0] && (r_state != S_IDLE)) begin
            err_busy <= 1'b1;
         end
         if (!en_proc) begin
            r_state <= S_IDLE;
            r_vpipe <= '0;
            r_fpipe <= '0;
            r_lpipe <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start[0]) begin
                     r_n      <= w_n;
                     r_page   <= BX[0];
                     bx_out   <= BX;
                     overflow <= w_ovf;
                     if (w_n == '0) begin
                        r_state <= S_DONE;
                     end else begin
                        // Address 0 goes out on the accepting edge to keep the
                        // whole readout inside one TMUX period.
                        read_add <= {BX[0], ADD_SIZE'(0)};
                        r_vpipe  <= {r_vpipe[RD_LATENCY-1:0], 1'b1};
                        r_fpipe  <= {r_fpipe[RD_LATENCY-1:0], 1'b1};
                        r_lpipe  <= {r_lpipe[RD_LATENCY-1:0], (w_n == CNT_W'(1))};
                        r_index  <= CNT_W'(1);
                        r_state  <= (w_n == CNT_W'(1)) ? S_DRAIN : S_READ;
                     end
                  end
               end
               S_READ: begin
                  read_add <= {r_page, ADD_SIZE'(r_index)};
                  r_vpipe  <= {r_vpipe[RD_LATENCY-1:0], 1'b1};
                  r_lpipe  <= {r_lpipe[RD_LATENCY-1:0], (r_index == w_last_idx)};
                  r_index  <= r_index + CNT_W'(1);
                  if (r_index == w_last_idx) begin
                     r_state <= S_DRAIN;
                  end
               end
               S_DRAIN: begin
                  if (w_drain_ok) begin
                     r_state <= S_DONE;
                  end
               end
               S_DONE: begin
                  r_done0 <= 1'b1;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Output stream register plus running word count and checksum.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out   <= '0;
         valid_out  <= 1'b0;
         first_out  <= 1'b0;
         last_out   <= 1'b0;
         word_count <= '0;
         checksum   <= '0;
      end else if (start[1]) begin
         data_out   <= '0;
         valid_out  <= 1'b0;
         first_out  <= 1'b0;
         last_out   <= 1'b0;
         word_count <= '0;
         checksum   <= '0;
      end else if (!en_proc) begin
         data_out   <= '0;
         valid_out  <= 1'b0;
         first_out  <= 1'b0;
         last_out   <= 1'b0;
      end else begin
         valid_out <= w_vtap;
         first_out <= w_vtap & r_fpipe[RD_LATENCY];
         last_out  <= w_vtap & r_lpipe[RD_LATENCY];
         data_out  <= w_vtap ? data_in : '0;
         if (w_accept) begin
            word_count <= '0;
            checksum   <= '0;
         end else if (w_vtap) begin
            word_count <= word_count + CNT_W'(1);
            checksum   <= checksum ^ data_in;
         end
      end
   end

endmodule
